// File: rtl/matrix_frame_sequencer.sv
// matrix_frame_sequencer: Wishbone B4 pipelined master that plays FRAME_COUNT stored 8-row frames into the RGB matrix driver.
// Latency: a tick or kick seen in cycle N raises stb in N+1; with a no-stall, next-cycle-ack slave o_done fires in N+9.
// Backpressure: stb, addr and wdata hold while i_wb_stall; a burst with no bus progress for TIMEOUT cycles is aborted.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_enable, i_kick           frame timer enable, one-cycle "send current frame now"
//   i_load_we/frame/row/data   frame store write port
//   o_wb_* / i_wb_*            Wishbone master (cyc, stb, we, addr, sel, wdata / ack, stall, rdata)
//   o_frame_idx, o_busy        current frame index, burst in progress
//   o_done, o_timeout          one-cycle pulses: burst completed / burst aborted
//   o_mismatch                 one-cycle pulse with o_done when readback differed
//
// Build option: define MATRIX_FRAME_SEQUENCER_READBACK_EN to read every frame back after writing it and
// compare against the frame store. Without it i_wb_rdata is ignored and o_mismatch is tied low.
module matrix_frame_sequencer #(
  parameter int FRAME_COUNT  = 4,
  parameter int FRAME_BITS   = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1,
  parameter int FRAME_PERIOD = 50_000_000,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic                  i_kick,
  input  logic                  i_load_we,
  input  logic [FRAME_BITS-1:0] i_load_frame,
  input  logic [2:0]            i_load_row,
  input  logic [31:0]           i_load_data,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [2:0]            o_wb_addr,
  output logic [3:0]            o_wb_sel,
  output logic [31:0]           o_wb_wdata,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic [31:0]           i_wb_rdata,
  output logic [FRAME_BITS-1:0] o_frame_idx,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout,
  output logic                  o_mismatch
);

  localparam int TIMER_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int PROG_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SADDR_W = FRAME_BITS + 3;
  localparam int DEPTH   = 1 << SADDR_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
`ifdef MATRIX_FRAME_SEQUENCER_READBACK_EN
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_READ   = 3'd4;
  localparam logic [2:0] S_RDRAIN = 3'd5;
`endif

  logic [2:0]             state;
  logic [2:0]             row;
  logic [3:0]             ack_cnt;
  logic [PROG_W-1:0]      prog;
  logic [FRAME_BITS-1:0]  idx;
  logic [FRAME_BITS-1:0]  idx_next;
  logic                   from_tick;
  logic [TIMER_W-1:0]     timer;
  logic [DEPTH-1:0][31:0] store;

  logic        tick;
  logic        busy;
  logic        cyc;
  logic        stb;
  logic        accept;
  logic        ack;
  logic        progress;
  logic        acks_done;
  logic        done;
  logic        timeout;
  logic        load_ok;
  logic [31:0] wr_word;

  // Frame timer: free-runs only while enabled, tick on the wrap cycle.
  assign tick = i_enable && (timer == TIMER_W'(FRAME_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset || !i_enable || tick) timer <= '0;
    else                            timer <= timer + 1'b1;
  end

  // Frame store; a write to a row not yet issued is picked up by the running burst.
  assign load_ok = i_load_we &&
                   ({{(32-FRAME_BITS){1'b0}}, i_load_frame} < 32'(FRAME_COUNT));

  always_ff @(posedge clk) begin
    if (reset)        store <= '0;
    else if (load_ok) store[{i_load_frame, i_load_row}] <= i_load_data;
  end

  assign wr_word = store[{idx, row}];

  // Bus phase decode.
  assign busy = (state != S_IDLE);
`ifdef MATRIX_FRAME_SEQUENCER_READBACK_EN
  assign cyc  = (state == S_WRITE) || (state == S_DRAIN) || (state == S_READ) || (state == S_RDRAIN);
  assign stb  = (state == S_WRITE) || (state == S_READ);
`else
  assign cyc  = (state == S_WRITE) || (state == S_DRAIN);
  assign stb  = (state == S_WRITE);
`endif

  assign accept    = stb && !i_wb_stall;
  assign ack       = cyc && i_wb_ack;
  assign progress  = accept || ack;
  // Count includes an ack arriving this cycle, so completion is seen in the cycle of the 8th ack.
  assign acks_done = (ack_cnt == 4'd8) || (ack && (ack_cnt == 4'd7));

`ifdef MATRIX_FRAME_SEQUENCER_READBACK_EN
  assign done = (state == S_RDRAIN) && acks_done;
`else
  assign done = (state == S_DRAIN) && acks_done;
`endif
  assign timeout = busy && (prog == PROG_W'(TIMEOUT)) && !progress && !done;

  assign idx_next = (idx == FRAME_BITS'(FRAME_COUNT - 1)) ? '0 : idx + 1'b1;

`ifdef MATRIX_FRAME_SEQUENCER_READBACK_EN
  // Read acks return in issue order, so the ack count names the row being compared.
  logic [31:0] cmp_word;
  logic        rd_miss;
  logic        mm_seen;

  assign cmp_word = store[{idx, ack_cnt[2:0]}];
  assign rd_miss  = ((state == S_READ) || (state == S_RDRAIN)) && ack &&
                    (ack_cnt < 4'd8) && (i_wb_rdata != cmp_word);
`else
  logic unused_rdata;
  assign unused_rdata = ^i_wb_rdata;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      row       <= 3'd0;
      ack_cnt   <= 4'd0;
      prog      <= '0;
      idx       <= '0;
      from_tick <= 1'b0;
`ifdef MATRIX_FRAME_SEQUENCER_READBACK_EN
      mm_seen   <= 1'b0;
`endif
    end else begin
      if (ack && (ack_cnt != 4'd8)) ack_cnt <= ack_cnt + 4'd1;
      if (accept)                   row     <= row + 3'd1;

      if (!busy || progress)             prog <= '0;
      else if (prog != PROG_W'(TIMEOUT)) prog <= prog + 1'b1;

`ifdef MATRIX_FRAME_SEQUENCER_READBACK_EN
      if (rd_miss) mm_seen <= 1'b1;
`endif

      case (state)
        S_IDLE: begin
          // A simultaneous tick and kick is one tick-initiated request.
          if (tick || i_kick) begin
            state     <= S_WRITE;
            from_tick <= tick;
            row       <= 3'd0;
            ack_cnt   <= 4'd0;
`ifdef MATRIX_FRAME_SEQUENCER_READBACK_EN
            mm_seen   <= 1'b0;
`endif
          end
        end
        S_WRITE: begin
          if (accept && (row == 3'd7)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (acks_done) begin
`ifdef MATRIX_FRAME_SEQUENCER_READBACK_EN
            state <= S_GAP;
`else
            state <= S_IDLE;
`endif
          end
        end
`ifdef MATRIX_FRAME_SEQUENCER_READBACK_EN
        // One cycle with cyc low separates the write and read bursts.
        S_GAP: begin
          state   <= S_READ;
          row     <= 3'd0;
          ack_cnt <= 4'd0;
        end
        S_READ: begin
          if (accept && (row == 3'd7)) state <= S_RDRAIN;
        end
        S_RDRAIN: begin
          if (acks_done) state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase

      if (timeout) state <= S_IDLE;
      if (done && from_tick) idx <= idx_next;
    end
  end

  assign o_wb_cyc    = cyc;
  assign o_wb_stb    = stb;
  assign o_wb_we     = (state == S_WRITE);
  assign o_wb_sel    = 4'hF;
  assign o_wb_addr   = stb ? row : 3'd0;
  assign o_wb_wdata  = (state == S_WRITE) ? wr_word : 32'd0;
  assign o_frame_idx = idx;
  assign o_busy      = busy;
  // Pulses are suppressed in a reset cycle so a reset mid-burst reports nothing.
  assign o_done      = done && !reset;
  assign o_timeout   = timeout && !reset;
`ifdef MATRIX_FRAME_SEQUENCER_READBACK_EN
  assign o_mismatch  = done && !reset && (mm_seen || rd_miss);
`else
  assign o_mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// tb_matrix_frame_sequencer: directed bench for the frame sequencer with a behavioural Wishbone slave.
// Latency: slave acks one cycle after each accepted strobe; stalls and ack cut-off are configurable per burst.
// Backpressure: slave stall is driven on the falling edge, ahead of the rising edge where it is sampled.
module tb_matrix_frame_sequencer;

  localparam int FC  = 4;
  localparam int FP  = 16;
  localparam int TO  = 20;
`ifdef MATRIX_FRAME_SEQUENCER_READBACK_EN
  localparam int RB  = 1;
  localparam int LAT = 19;
`else
  localparam int RB  = 0;
  localparam int LAT = 9;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_kick = 1'b0;
  logic        i_load_we = 1'b0;
  logic [1:0]  i_load_frame = '0;
  logic [2:0]  i_load_row = '0;
  logic [31:0] i_load_data = '0;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_stall = 1'b0;
  logic [31:0] i_wb_rdata = '0;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [2:0]  o_wb_addr;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_wdata;
  logic [1:0]  o_frame_idx;
  logic        o_busy, o_done, o_timeout, o_mismatch;

  matrix_frame_sequencer #(.FRAME_COUNT(FC), .FRAME_PERIOD(FP), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_kick(i_kick),
    .i_load_we(i_load_we), .i_load_frame(i_load_frame), .i_load_row(i_load_row), .i_load_data(i_load_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_sel(o_wb_sel), .o_wb_wdata(o_wb_wdata), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
    .i_wb_rdata(i_wb_rdata), .o_frame_idx(o_frame_idx), .o_busy(o_busy), .o_done(o_done),
    .o_timeout(o_timeout), .o_mismatch(o_mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } beat_t;

  // One burst scenario: trigger kind and slave stall (inputs), frame sent and index after (expected).
  typedef struct {
    bit         use_tick;
    int         stall_row;
    int         exp_frame;
    logic [1:0] exp_idx;
  } vec_t;

  beat_t       wr_log[$];
  beat_t       rd_log[$];
  logic [31:0] exp_mem [FC][8];

  // Slave configuration and state.
  int          stall_row = -1;
  int          stall_left = 0;
  int          ack_limit = 16;
  int          acc_cnt = 0;
  bit          corrupt = 1'b0;
  logic [31:0] smem [8];
  logic        pend_ack = 1'b0;
  logic [31:0] pend_rdata = '0;

  // Monitor counters.
  int          cyc_no = 0;
  int          done_cnt = 0;
  int          to_cnt = 0;
  int          mm_cnt = 0;
  int          done_cyc = 0;
  int          stall_cycles = 0;
  int          hold_err = 0;
  int          gapc = 0;
  logic        prev_stall_stb = 1'b0;
  logic [2:0]  prev_addr = '0;
  logic [31:0] prev_data = '0;

  int pass_cnt = 0;
  int total_cnt = 0;
  int d0, t0, m0, start_c;

  always @(negedge clk) begin
    cyc_no++;
    i_wb_ack   = pend_ack;
    i_wb_rdata = pend_rdata;
    i_wb_stall = o_wb_stb && (int'(o_wb_addr) == stall_row) && (stall_left > 0);
    if (i_wb_stall) stall_left--;
    pend_ack = 1'b0;
    if (o_wb_stb && !i_wb_stall) begin
      acc_cnt++;
      pend_ack = (acc_cnt <= ack_limit);
      if (o_wb_we) smem[o_wb_addr] = o_wb_wdata;
      pend_rdata = smem[o_wb_addr] ^ ((corrupt && o_wb_addr == 3'd2) ? 32'h1 : 32'h0);
    end
    #1;
    if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
      if (o_wb_we) wr_log.push_back('{o_wb_we, o_wb_addr, o_wb_wdata, o_wb_sel});
      else         rd_log.push_back('{o_wb_we, o_wb_addr, o_wb_wdata, o_wb_sel});
    end
    if (o_wb_stb && i_wb_stall) stall_cycles++;
    if (prev_stall_stb && (!o_wb_stb || o_wb_addr != prev_addr || o_wb_wdata != prev_data)) hold_err++;
    prev_stall_stb = o_wb_stb && i_wb_stall;
    prev_addr      = o_wb_addr;
    prev_data      = o_wb_wdata;
    if (o_busy && !o_wb_cyc) gapc++;
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc_no;
      if (o_mismatch) mm_cnt++;
    end
    if (o_timeout) to_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic load(input int f, input int r, input logic [31:0] d);
    i_load_we    = 1'b1;
    i_load_frame = 2'(f);
    i_load_row   = 3'(r);
    i_load_data  = d;
    exp_mem[f][r] = d;
    step();
    i_load_we = 1'b0;
  endtask

  // Starts a burst and waits (bounded) for o_done or o_timeout.
  task automatic do_burst(input bit use_tick, input int srow, input int alimit);
    wr_log.delete();
    rd_log.delete();
    stall_row = srow; stall_left = 2; ack_limit = alimit; acc_cnt = 0;
    stall_cycles = 0; hold_err = 0; gapc = 0;
    d0 = done_cnt; t0 = to_cnt; m0 = mm_cnt;
    if (use_tick) i_enable = 1'b1;
    else          i_kick = 1'b1;
    start_c = cyc_no;
    step();
    i_kick = 1'b0;
    for (int n = 0; n < 200 && done_cnt == d0 && to_cnt == t0; n++) step();
    i_enable = 1'b0;
    check("burst ended", (done_cnt != d0 || to_cnt != t0), 1);
  endtask

  function automatic int beat_errs(input int f);
    int e = 0;
    if (wr_log.size() != 8) return 99;
    for (int i = 0; i < 8; i++)
      if (wr_log[i].addr != 3'(i) || wr_log[i].data != exp_mem[f][i] ||
          wr_log[i].sel != 4'hF || !wr_log[i].we) e++;
    return e;
  endfunction

  function automatic int read_errs();
    int e = 0;
    if (rd_log.size() != 8) return 99;
    for (int i = 0; i < 8; i++)
      if (rd_log[i].addr != 3'(i) || rd_log[i].we) e++;
    return e;
  endfunction

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, -1, 0, 2'd1};
    vecs[1] = '{1'b1,  3, 1, 2'd2};
    vecs[2] = '{1'b1, -1, 2, 2'd3};
    vecs[3] = '{1'b1, -1, 3, 2'd0};
    vecs[4] = '{1'b1, -1, 0, 2'd1};
    vecs[5] = '{1'b0, -1, 1, 2'd1};

    repeat (3) step();
    check("reset cyc", o_wb_cyc, 0);
    check("reset stb", o_wb_stb, 0);
    check("reset we", o_wb_we, 0);
    check("reset sel", o_wb_sel, 4'hF);
    check("reset wdata", o_wb_wdata, 0);
    check("reset idx", o_frame_idx, 0);
    check("reset busy", o_busy, 0);
    reset = 1'b0;
    step();

    for (int f = 0; f < FC; f++)
      for (int r = 0; r < 8; r++)
        load(f, r, {4'(f), 4'(r), 24'h666600});

    for (int v = 0; v < 6; v++) begin
      do_burst(vecs[v].use_tick, vecs[v].stall_row, 16);
      step();
      step();
      check($sformatf("vec%0d beats", v), beat_errs(vecs[v].exp_frame), 0);
      check($sformatf("vec%0d idx", v), o_frame_idx, vecs[v].exp_idx);
      check($sformatf("vec%0d done pulses", v), done_cnt - d0, 1);
      check($sformatf("vec%0d cyc-low gap", v), gapc, RB);
      if (vecs[v].stall_row >= 0) begin
        check($sformatf("vec%0d stall cycles", v), stall_cycles, 2);
        check($sformatf("vec%0d stall hold", v), hold_err, 0);
      end
      if (!vecs[v].use_tick) check($sformatf("vec%0d latency", v), done_cyc - start_c, LAT);
`ifdef MATRIX_FRAME_SEQUENCER_READBACK_EN
      check($sformatf("vec%0d reads", v), read_errs(), 0);
      check($sformatf("vec%0d mismatch", v), mm_cnt - m0, 0);
`endif
    end

    // Slave stops acking after row 5: abort, index kept, next tick resends frame 1.
    do_burst(1'b1, -1, 6);
    step();
    check("timeout cyc low", o_wb_cyc, 0);
    check("timeout idx", o_frame_idx, 1);
    check("timeout no done", done_cnt - d0, 0);
    repeat (20) step();
    check("timeout pulses", to_cnt - t0, 1);
    do_burst(1'b1, -1, 16);
    step();
    check("resend beats", beat_errs(1), 0);
    check("resend idx", o_frame_idx, 2);

    // Kick while idle starts a burst; a second kick mid-burst is dropped.
    wr_log.delete();
    rd_log.delete();
    d0 = done_cnt; acc_cnt = 0; stall_row = -1;
    i_kick = 1'b1; step(); i_kick = 1'b0;
    step(); step();
    i_kick = 1'b1; step(); i_kick = 1'b0;
    repeat (40) step();
    check("kick drop done pulses", done_cnt - d0, 1);
    check("kick drop beats", beat_errs(2), 0);
    check("kick drop idx", o_frame_idx, 2);

`ifdef MATRIX_FRAME_SEQUENCER_READBACK_EN
    corrupt = 1'b1;
    do_burst(1'b0, -1, 16);
    corrupt = 1'b0;
    step();
    check("corrupt mismatch", mm_cnt - m0, 1);
    check("corrupt reads", read_errs(), 0);
    check("corrupt gap", gapc, 1);
    check("corrupt beats", beat_errs(2), 0);
`endif

    // Reset mid-burst: bus released next cycle, no completion, store cleared.
    d0 = done_cnt; t0 = to_cnt; acc_cnt = 0;
    i_kick = 1'b1; step(); i_kick = 1'b0;
    repeat (3) step();
    check("pre-reset busy", o_busy, 1);
    reset = 1'b1;
    step();
    check("mid reset cyc", o_wb_cyc, 0);
    check("mid reset stb", o_wb_stb, 0);
    check("mid reset busy", o_busy, 0);
    reset = 1'b0;
    repeat (15) step();
    check("mid reset no done", done_cnt - d0, 0);
    check("mid reset no timeout", to_cnt - t0, 0);
    check("mid reset idx", o_frame_idx, 0);
    for (int f = 0; f < FC; f++)
      for (int r = 0; r < 8; r++)
        exp_mem[f][r] = 32'h0;
    do_burst(1'b0, -1, 16);
    step();
    check("cleared store beats", beat_errs(0), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
